// File: rtl/pss_correlator_mc.sv
`default_nettype none
// ============================================================================
// Module   : pss_correlator_mc
// Brief    : Multi-channel sliding complex correlator with peak detect/holdoff
// Revision : 1.0
// ============================================================================
module pss_correlator_mc #(
  parameter int IN_DW   = 32,
  parameter int OUT_DW  = 48,
  parameter int PSS_LEN = 127,
  parameter int NUM_CH  = 3,
  parameter int TAP_DW  = 32,
  parameter logic [NUM_CH*PSS_LEN*TAP_DW-1:0] PSS_LOCAL = '0,
  parameter int HOLDOFF = 64,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [IN_DW-1:0]         s_axis_in_tdata,
  input  logic                     s_axis_in_tvalid,
  input  logic [OUT_DW-1:0]        threshold_i,
  output logic [NUM_CH*OUT_DW-1:0] m_axis_out_tdata,
  output logic                     m_axis_out_tvalid,
  output logic                     peak_valid_o,
  output logic [CH_W-1:0]          peak_ch_o,
  output logic [OUT_DW-1:0]        peak_mag_o
);
  localparam int IH     = IN_DW / 2;
  localparam int TH     = TAP_DW / 2;
  localparam int CW     = IH + TH + 1 + $clog2(PSS_LEN);
  localparam int MW     = 2 * CW + 1;
  localparam int FILL_W = $clog2(PSS_LEN + 1);
  localparam int HC_W   = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PSS_LEN);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PSS_LEN - 1);

  typedef enum logic [0:0] {SEARCH = 1'b0, HOLD = 1'b1} state_t;

  logic [IN_DW-1:0]         win_q [PSS_LEN];
  logic [IN_DW-1:0]         win_d [PSS_LEN];
  logic [FILL_W-1:0]        fill_q, fill_d;
  logic                     acc_q, acc_d;
  logic signed [CW-1:0]     corr_re_q [NUM_CH];
  logic signed [CW-1:0]     corr_im_q [NUM_CH];
  logic signed [CW-1:0]     corr_re_d [NUM_CH];
  logic signed [CW-1:0]     corr_im_d [NUM_CH];
  logic                     v1_q, v1_d;
  logic [NUM_CH*OUT_DW-1:0] mag_vec;
  logic [NUM_CH*OUT_DW-1:0] tdata_q, tdata_d;
  logic                     tvalid_q, tvalid_d;
  state_t                   state_q, state_d;
  logic [HC_W-1:0]          hold_q, hold_d;
  logic                     peak_valid_q, peak_valid_d;
  logic [CH_W-1:0]          peak_ch_q, peak_ch_d;
  logic [OUT_DW-1:0]        peak_mag_q, peak_mag_d;

  // Window and fill count move only on accepted samples.
  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    acc_d  = s_axis_in_tvalid && (fill_q >= FILL_LAST);
    if (s_axis_in_tvalid) begin
      for (int i = 0; i < PSS_LEN - 1; i++) win_d[i] = win_q[i+1];
      win_d[PSS_LEN-1] = s_axis_in_tdata;
      if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
    end
  end

  // in * conj(tap): re = a*c + b*d, im = b*c - a*d
  always_comb begin
    logic signed [CW-1:0] xr, xi, tr, ti, sr, si;
    for (int c = 0; c < NUM_CH; c++) begin
      sr = '0;
      si = '0;
      for (int i = 0; i < PSS_LEN; i++) begin
        xr = CW'($signed(win_q[i][IH-1:0]));
        xi = CW'($signed(win_q[i][IN_DW-1:IH]));
        tr = CW'($signed(PSS_LOCAL[(c*PSS_LEN+i)*TAP_DW +: TH]));
        ti = CW'($signed(PSS_LOCAL[(c*PSS_LEN+i)*TAP_DW+TH +: TH]));
        sr = sr + xr * tr + xi * ti;
        si = si + xi * tr - xr * ti;
      end
      corr_re_d[c] = sr;
      corr_im_d[c] = si;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [2*CW-1:0] sq_re, sq_im;
    logic [MW-1:0]          mag;
    logic [OUT_DW-1:0]      mag_sat;
    always_comb begin
      sq_re = (2*CW)'(corr_re_q[c]) * (2*CW)'(corr_re_q[c]);
      sq_im = (2*CW)'(corr_im_q[c]) * (2*CW)'(corr_im_q[c]);
      mag   = MW'($unsigned(sq_re)) + MW'($unsigned(sq_im));
    end
    if (MW > OUT_DW) begin : g_sat
      assign mag_sat = (|mag[MW-1:OUT_DW]) ? {OUT_DW{1'b1}} : mag[OUT_DW-1:0];
    end else begin : g_nosat
      assign mag_sat = OUT_DW'(mag);
    end
    assign mag_vec[c*OUT_DW +: OUT_DW] = mag_sat;
  end

  always_comb begin
    v1_d     = acc_q;
    tvalid_d = v1_q;
    tdata_d  = v1_q ? mag_vec : '0;
  end

  // Peak search: strict compare, lowest channel wins ties.
  always_comb begin
    logic [OUT_DW-1:0] best_mag;
    logic [CH_W-1:0]   best_ch;
    state_d      = state_q;
    hold_d       = hold_q;
    peak_valid_d = 1'b0;
    peak_ch_d    = peak_ch_q;
    peak_mag_d   = peak_mag_q;
    best_mag     = tdata_q[0 +: OUT_DW];
    best_ch      = '0;
    for (int c = 1; c < NUM_CH; c++) begin
      if (tdata_q[c*OUT_DW +: OUT_DW] > best_mag) begin
        best_mag = tdata_q[c*OUT_DW +: OUT_DW];
        best_ch  = CH_W'(c);
      end
    end
    case (state_q)
      SEARCH: begin
        if (tvalid_q && (best_mag > threshold_i)) begin
          peak_valid_d = 1'b1;
          peak_ch_d    = best_ch;
          peak_mag_d   = best_mag;
          if (HOLDOFF > 0) begin
            state_d = HOLD;
            hold_d  = HC_W'(HOLDOFF);
          end
        end
      end
      HOLD: begin
        if (tvalid_q) begin
          hold_d = hold_q - 1'b1;
          if (hold_q == HC_W'(1)) state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      win_q        <= '{default: '0};
      fill_q       <= '0;
      acc_q        <= 1'b0;
      corr_re_q    <= '{default: '0};
      corr_im_q    <= '{default: '0};
      v1_q         <= 1'b0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      state_q      <= SEARCH;
      hold_q       <= '0;
      peak_valid_q <= 1'b0;
      peak_ch_q    <= '0;
      peak_mag_q   <= '0;
    end else begin
      win_q        <= win_d;
      fill_q       <= fill_d;
      acc_q        <= acc_d;
      corr_re_q    <= corr_re_d;
      corr_im_q    <= corr_im_d;
      v1_q         <= v1_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      state_q      <= state_d;
      hold_q       <= hold_d;
      peak_valid_q <= peak_valid_d;
      peak_ch_q    <= peak_ch_d;
      peak_mag_q   <= peak_mag_d;
    end
  end

  assign m_axis_out_tdata  = tdata_q;
  assign m_axis_out_tvalid = tvalid_q;
  assign peak_valid_o      = peak_valid_q;
  assign peak_ch_o         = peak_ch_q;
  assign peak_mag_o        = peak_mag_q;

endmodule
`default_nettype wire

// File: tb/tb_pss_correlator_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_pss_correlator_mc
// Brief    : Scoreboard bench for pss_correlator_mc against a queue-based model
// Revision : 1.0
// ============================================================================
module tb_pss_correlator_mc;
  localparam int L = 127, NCH = 3, IN_DW = 32, OUT_DW = 48, TAP_DW = 32, HOLD = 4;
  localparam int TW = NCH * L * TAP_DW;
  localparam logic [127:0] SAT = (128'd1 << OUT_DW) - 128'd1;

  // Channels 0 and 2 share one sequence, channel 1 has its own.
  function automatic logic [TW-1:0] gen_taps();
    logic [TW-1:0] t;
    logic [31:0]   s;
    logic [15:0]   re, im;
    t = '0;
    s = 32'h2545_F491;
    for (int i = 0; i < L; i++) begin
      s = s * 32'd1103515245 + 32'd12345;
      re = 16'(int'(s[18:16]) - 3);
      im = 16'(int'(s[26:24]) - 3);
      t[i*TAP_DW +: TAP_DW]         = {im, re};
      t[(2*L+i)*TAP_DW +: TAP_DW]   = {im, re};
      s = s * 32'd1103515245 + 32'd12345;
      re = 16'(int'(s[18:16]) - 3);
      im = 16'(int'(s[26:24]) - 3);
      t[(L+i)*TAP_DW +: TAP_DW]     = {im, re};
    end
    return t;
  endfunction
  localparam logic [TW-1:0] TAPS = gen_taps();

  typedef struct { int re; int im; } cplx_t;
  typedef struct { int cyc; logic [NCH*OUT_DW-1:0] data; } out_t;
  typedef struct { int cyc; int ch; logic [OUT_DW-1:0] mag; } pk_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [IN_DW-1:0] in_data = '0;
  logic in_valid = 1'b0;
  logic [OUT_DW-1:0] thr = '1;
  logic [NCH*OUT_DW-1:0] tdata, h0_tdata;
  logic tvalid, h0_tvalid, pk_v, h0_pk_v;
  logic [1:0] pk_ch, h0_pk_ch;
  logic [OUT_DW-1:0] pk_mag, h0_pk_mag;
  logic sat_rst_n = 1'b0;
  logic [NCH*16-1:0] sat_tdata;
  logic sat_tvalid, sat_pk_v;
  logic [1:0] sat_pk_ch;
  logic [15:0] sat_pk_mag;

  int cyc = 0, checks = 0, failures = 0;
  int n_out = 0, n_pk = 0, n_pk0 = 0, sat_n = 0, skip_m = 0;
  bit mon_en = 0, sat_en = 0;
  cplx_t win_m[$];
  out_t  exp_q[$];
  pk_t   pk_q[$], pk0_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pss_correlator_mc #(.IN_DW(IN_DW), .OUT_DW(OUT_DW), .PSS_LEN(L), .NUM_CH(NCH),
    .TAP_DW(TAP_DW), .PSS_LOCAL(TAPS), .HOLDOFF(HOLD)) dut (
    .clk_i(clk), .reset_ni(rst_n), .s_axis_in_tdata(in_data), .s_axis_in_tvalid(in_valid),
    .threshold_i(thr), .m_axis_out_tdata(tdata), .m_axis_out_tvalid(tvalid),
    .peak_valid_o(pk_v), .peak_ch_o(pk_ch), .peak_mag_o(pk_mag));

  pss_correlator_mc #(.IN_DW(IN_DW), .OUT_DW(OUT_DW), .PSS_LEN(L), .NUM_CH(NCH),
    .TAP_DW(TAP_DW), .PSS_LOCAL(TAPS), .HOLDOFF(0)) dut_h0 (
    .clk_i(clk), .reset_ni(rst_n), .s_axis_in_tdata(in_data), .s_axis_in_tvalid(in_valid),
    .threshold_i(thr), .m_axis_out_tdata(h0_tdata), .m_axis_out_tvalid(h0_tvalid),
    .peak_valid_o(h0_pk_v), .peak_ch_o(h0_pk_ch), .peak_mag_o(h0_pk_mag));

  pss_correlator_mc #(.IN_DW(32), .OUT_DW(16), .PSS_LEN(L), .NUM_CH(NCH), .TAP_DW(32),
    .PSS_LOCAL({(NCH*L){32'h7FFF_7FFF}}), .HOLDOFF(HOLD)) dut_sat (
    .clk_i(clk), .reset_ni(sat_rst_n), .s_axis_in_tdata(32'h7FFF_7FFF), .s_axis_in_tvalid(1'b1),
    .threshold_i(16'h0000), .m_axis_out_tdata(sat_tdata), .m_axis_out_tvalid(sat_tvalid),
    .peak_valid_o(sat_pk_v), .peak_ch_o(sat_pk_ch), .peak_mag_o(sat_pk_mag));

  function automatic void chk(string name, logic [159:0] got, logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic longint tap_re(int c, int i);
    return longint'($signed(TAPS[(c*L+i)*TAP_DW +: 16]));
  endfunction
  function automatic longint tap_im(int c, int i);
    return longint'($signed(TAPS[(c*L+i)*TAP_DW+16 +: 16]));
  endfunction

  // Direct complex correlation over the model window, saturated to OUT_DW.
  function automatic logic [NCH*OUT_DW-1:0] model_mags();
    logic [NCH*OUT_DW-1:0] r;
    longint cr, ci, a, b, tr, ti;
    logic [127:0] ur, ui, m;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      cr = 0;
      ci = 0;
      for (int i = 0; i < L; i++) begin
        a = longint'(win_m[i].re);
        b = longint'(win_m[i].im);
        tr = tap_re(c, i);
        ti = tap_im(c, i);
        cr += a * tr + b * ti;
        ci += b * tr - a * ti;
      end
      ur = 128'(cr < 0 ? -cr : cr);
      ui = 128'(ci < 0 ? -ci : ci);
      m = ur * ur + ui * ui;
      r[c*OUT_DW +: OUT_DW] = (m > SAT) ? OUT_DW'(SAT) : OUT_DW'(m);
    end
    return r;
  endfunction

  task automatic model_output();
    out_t o;
    pk_t p;
    logic [OUT_DW-1:0] best;
    int bch;
    o.cyc = cyc + 3;
    o.data = model_mags();
    exp_q.push_back(o);
    best = o.data[0 +: OUT_DW];
    bch = 0;
    for (int c = 1; c < NCH; c++)
      if (o.data[c*OUT_DW +: OUT_DW] > best) begin best = o.data[c*OUT_DW +: OUT_DW]; bch = c; end
    p.cyc = cyc + 4;
    p.ch = bch;
    p.mag = best;
    if (best > thr) pk0_q.push_back(p);
    if (skip_m > 0) skip_m--;
    else if (best > thr) begin pk_q.push_back(p); skip_m = HOLD; end
  endtask

  task automatic send(input logic v, input logic [31:0] d);
    cplx_t s;
    @(posedge clk); #1;
    in_valid = v;
    in_data = d;
    if (v) begin
      s.re = int'($signed(d[15:0]));
      s.im = int'($signed(d[31:16]));
      win_m.push_back(s);
      if (win_m.size() > L) void'(win_m.pop_front());
      if (win_m.size() == L) model_output();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, 32'h0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    exp_q.delete(); pk_q.delete(); pk0_q.delete(); win_m.delete();
    skip_m = 0;
    mon_en = 1;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_peak_valid", pk_v, 0);
    chk("rst_peak_ch", pk_ch, 0);
    chk("rst_peak_mag", pk_mag, 0);
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) if (mon_en) begin
    out_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      chk("out_missing", 0, 1);
      void'(exp_q.pop_front());
    end
    if (tvalid) begin
      n_out++;
      if (exp_q.size() == 0) chk("out_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("out_cycle", cyc, e.cyc);
        chk("out_data", tdata, e.data);
      end
    end else chk("out_idle_zero", tdata, 0);
  end

  always @(negedge clk) if (mon_en) begin
    pk_t e;
    while (pk_q.size() > 0 && pk_q[0].cyc < cyc) begin
      chk("peak_missing", 0, 1);
      void'(pk_q.pop_front());
    end
    if (pk_v) begin
      n_pk++;
      if (pk_q.size() == 0) chk("peak_unexpected", 1, 0);
      else begin
        e = pk_q.pop_front();
        chk("peak_cycle", cyc, e.cyc);
        chk("peak_ch", pk_ch, e.ch);
        chk("peak_mag", pk_mag, e.mag);
      end
    end
  end

  always @(negedge clk) if (mon_en) begin
    pk_t e;
    while (pk0_q.size() > 0 && pk0_q[0].cyc < cyc) begin
      chk("h0_peak_missing", 0, 1);
      void'(pk0_q.pop_front());
    end
    if (h0_pk_v) begin
      n_pk0++;
      if (pk0_q.size() == 0) chk("h0_peak_unexpected", 1, 0);
      else begin
        e = pk0_q.pop_front();
        chk("h0_peak_cycle", cyc, e.cyc);
        chk("h0_peak_ch", h0_pk_ch, e.ch);
        chk("h0_peak_mag", h0_pk_mag, e.mag);
      end
    end
  end

  always @(negedge clk) if (sat_en && sat_tvalid) begin
    sat_n++;
    chk("sat_mag", sat_tdata, {NCH{16'hFFFF}});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, p0, q0;
    repeat (3) @(posedge clk);
    #1 sat_rst_n = 1'b1;
    sat_en = 1;
  end

  initial begin
    int o0, p0, q0;
    do_reset(2);

    // Fill rule: 126 samples give nothing, the 127th gives one output.
    for (int i = 0; i < L - 1; i++) send(1'b1, 32'h0000_0001);
    idle(5);
    chk("fill_no_out", n_out, 0);
    send(1'b1, 32'h0000_0001);
    idle(5);
    chk("fill_first_out", n_out, 1);

    // Exact match on channel 1.
    thr = 48'd1;
    do_reset(2);
    p0 = n_pk;
    for (int i = 0; i < L; i++) send(1'b1, TAPS[(L+i)*TAP_DW +: 32]);
    idle(6);
    chk("ch1_peak_count", n_pk - p0, 1);
    chk("ch1_peak_ch_held", pk_ch, 1);

    // Identical channels 0 and 2: lowest index wins.
    do_reset(2);
    p0 = n_pk;
    for (int i = 0; i < L; i++) send(1'b1, TAPS[i*TAP_DW +: 32]);
    idle(6);
    chk("tie_peak_count", n_pk - p0, 1);
    chk("tie_peak_ch", pk_ch, 0);

    // Continuous above-threshold outputs: holdoff 4 vs holdoff 0.
    thr = '0;
    do_reset(2);
    o0 = n_out; p0 = n_pk; q0 = n_pk0;
    for (int i = 0; i < L + 40; i++) send(1'b1, $urandom());
    idle(6);
    chk("cont_outputs", n_out - o0, 41);
    chk("hold4_strobes", n_pk - p0, 9);
    chk("hold0_strobes", n_pk0 - q0, 41);

    // Random gaps with resets landing mid-window.
    thr = 48'd1 << $urandom_range(36, 41);
    do_reset(2);
    for (int i = 0; i < 1000; i++) begin
      if (i == 300 || i == 650) do_reset($urandom_range(1, 3));
      send(1'(($urandom() >> 3) & 1), $urandom());
    end
    idle(8);

    chk("exp_drained", exp_q.size(), 0);
    chk("peak_drained", pk_q.size(), 0);
    chk("h0_peak_drained", pk0_q.size(), 0);
    chk("sat_outputs_seen", (sat_n > 0), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pss_correlator_mc.md
PSS_CORRELATOR_MC -- requirements
Module: pss_correlator_mc

Interface
REQ-001 Parameter IN_DW, default 32: input sample width; signed re in [IN_DW/2-1:0], signed im in [IN_DW-1:IN_DW/2].
REQ-002 Parameter OUT_DW, default 48: width of each unsigned per-channel magnitude.
REQ-003 Parameter PSS_LEN, default 127: correlation window length in samples.
REQ-004 Parameter NUM_CH, default 3: number of local sequences (N_id_2 hypotheses) correlated in parallel.
REQ-005 Parameter TAP_DW, default 32: tap width; signed re in low half, signed im in high half.
REQ-006 Parameter PSS_LOCAL, default all zero, width NUM_CH*PSS_LEN*TAP_DW: tap i of channel c at bit offset (c*PSS_LEN+i)*TAP_DW.
REQ-007 Parameter HOLDOFF, default 64: valid correlation outputs ignored after a detected peak.
REQ-008 clk_i  in  1  single clock; all logic on rising edge.
REQ-009 reset_ni  in  1  reset, synchronous, active-low.
REQ-010 s_axis_in_tdata  in  IN_DW  complex input sample.
REQ-011 s_axis_in_tvalid  in  1  sample qualifier; no backpressure.
REQ-012 threshold_i  in  OUT_DW  detection threshold, sampled every cycle.
REQ-013 m_axis_out_tdata  out  NUM_CH*OUT_DW  magnitude of channel c at [c*OUT_DW +: OUT_DW].
REQ-014 m_axis_out_tvalid  out  1  magnitude qualifier.
REQ-015 peak_valid_o  out  1  one-cycle peak strobe.
REQ-016 peak_ch_o  out  max(1,$clog2(NUM_CH))  winning channel index.
REQ-017 peak_mag_o  out  OUT_DW  winning magnitude.

Function
REQ-018 Window SHALL shift on each s_axis_in_tvalid cycle only; newest sample at index PSS_LEN-1, oldest at 0.
REQ-019 Per channel: corr = sum over i of in[i]*conj(tap[i]); magnitude = re^2 + im^2, all at full internal precision, no input truncation.
REQ-020 Magnitude above 2^OUT_DW-1 SHALL saturate to 2^OUT_DW-1, never wrap.
REQ-021 Fill counter SHALL count accepted samples, saturating at PSS_LEN; m_axis_out_tvalid stays 0 until the PSS_LEN-th sample is accepted.
REQ-022 Latency: sample accepted at edge k -> m_axis_out_tvalid/tdata at edge k+2; one output per accepted sample once full.
REQ-023 When m_axis_out_tvalid is 0, m_axis_out_tdata SHALL be 0.
REQ-024 Peak FSM states SEARCH and HOLD; reset state SEARCH.
REQ-025 SEARCH: on a valid output where some channel magnitude > threshold_i (strict), SHALL assert peak_valid_o at the next edge (k+3) with the maximum channel; ties go to the lowest index; transition to HOLD, load hold counter with HOLDOFF.
REQ-026 HOLD: decrement counter on each valid output; no peak strobes; return to SEARCH on the valid output that brings the counter to 0; that output is not evaluated.
REQ-027 HOLDOFF = 0: FSM SHALL remain in SEARCH; every above-threshold output strobes.
REQ-028 peak_ch_o/peak_mag_o SHALL hold last values between strobes; peak_valid_o high exactly one cycle per detection.
REQ-029 Gaps in s_axis_in_tvalid SHALL freeze window, fill counter and hold counter.

Reset
REQ-030 While reset_ni = 0 at an edge: window, fill counter, hold counter cleared; FSM to SEARCH; all outputs 0.
REQ-031 Reset mid-operation SHALL discard in-flight pipeline results; no valid or peak output until PSS_LEN new samples accepted.

Verification
REQ-032 Reset, then 126 valid samples of 1+j0 -> m_axis_out_tvalid stays 0; 127th sample -> tvalid high exactly 2 cycles later.
REQ-033 Channel 1 taps = PSS sequence, input = same sequence, threshold_i = 1 -> exactly one peak strobe, peak_ch_o = 1, peak_mag_o equals golden model.
REQ-034 Two identical channels (0 and 2) matching input -> peak_ch_o = 0 (tie rule).
REQ-035 Continuous above-threshold input, HOLDOFF = 4 -> strobes on valid outputs 1, 6, 11, ...; HOLDOFF = 0 -> strobe on every valid output.
REQ-036 Max-amplitude input 0x7FFF+j0x7FFF with taps of max amplitude, OUT_DW = 16 -> all magnitudes 0xFFFF, no wrap.
REQ-037 Random valid gaps (50%), reset asserted mid-window -> outputs match gap-free golden model per accepted sample; post-reset fill rule per REQ-031 holds.
